// File: rtl/mem_rr_arbiter_if.sv
// Requester-side bus for mem_rr_arbiter.
// The lock vector only exists when MEM_ARB_LOCK_EN is defined.
interface mem_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
);
  localparam int AW  = $clog2(DEPTH);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  rvalid;
  logic [WIDTH-1:0]      rdata;
  logic [IDW-1:0]        rid;
  logic                  init_busy;
`ifdef MEM_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output lock,
`endif
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, rid, init_busy
  );

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  lock,
`endif
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, rid, init_busy
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter in front of a DEPTH x WIDTH register memory, cleared after reset.
// Define MEM_ARB_LOCK_EN to add exclusive-ownership locking through bus.lock.
//
// state     | meaning
// ST_INIT   | clearing one word per cycle, no grants
// ST_SERVE  | round-robin grant, one access per cycle
// ST_LOCKED | only the lock owner may be granted (MEM_ARB_LOCK_EN only)
module mem_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  mem_rr_arbiter_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_INIT, ST_SERVE, ST_LOCKED} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] mem [DEPTH];
`ifdef MEM_ARB_LOCK_EN
  logic [IDW-1:0]   owner;
`endif

  logic             rr_any;
  logic [IDW-1:0]   rr_sel;
  logic             acc_any;
  logic [IDW-1:0]   acc_idx;
  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    int j;
    j      = 0;
    rr_any = 1'b0;
    rr_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req[j]) begin
        rr_any = 1'b1;
        rr_sel = IDW'(j);
      end
    end
  end

  always_comb begin
    acc_any = 1'b0;
    acc_idx = '0;
    case (state)
      ST_SERVE: begin
        acc_any = rr_any;
        acc_idx = rr_sel;
      end
`ifdef MEM_ARB_LOCK_EN
      // The cycle lock drops is spent leaving the state, not granting.
      ST_LOCKED: begin
        acc_any = bus.req[owner] && bus.lock[owner];
        acc_idx = owner;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    bus.gnt = '0;
    if (acc_any) bus.gnt[acc_idx] = 1'b1;
  end

  assign acc_we    = bus.we[acc_idx];
  assign acc_addr  = bus.addr[int'(acc_idx)*AW +: AW];
  assign acc_wdata = bus.wdata[int'(acc_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      mem[cnt] <= '0;
    else if (acc_any && acc_we)
      mem[acc_addr] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_INIT;
      cnt           <= '0;
      ptr           <= '0;
      bus.rvalid    <= 1'b0;
      bus.rdata     <= '0;
      bus.rid       <= '0;
      bus.init_busy <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
      owner         <= '0;
`endif
    end else begin
      bus.rvalid <= 1'b0;
      if (acc_any && !acc_we) begin
        bus.rdata  <= mem[acc_addr];
        bus.rid    <= acc_idx;
        bus.rvalid <= 1'b1;
      end
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state         <= ST_SERVE;
            bus.init_busy <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (acc_any) begin
            ptr <= ptr_after(acc_idx);
`ifdef MEM_ARB_LOCK_EN
            if (bus.lock[acc_idx]) begin
              state <= ST_LOCKED;
              owner <= acc_idx;
            end
`endif
          end
        end
`ifdef MEM_ARB_LOCK_EN
        ST_LOCKED: begin
          if (!bus.lock[owner]) begin
            state <= ST_SERVE;
            ptr   <= ptr_after(owner);
          end
        end
`endif
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomized self-checking bench for mem_rr_arbiter against a behavioural model.
// Lock scenarios run only when MEM_ARB_LOCK_EN is defined.
module tb_mem_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int ADDRW = NREQ * AW;
  localparam int DATW  = NREQ * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] lock_drv = '0;

  int errors = 0;
  int checks = 0;

  mem_rr_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
`ifdef MEM_ARB_LOCK_EN
  assign bus.lock = lock_drv;
`endif

  mem_rr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_mem [DEPTH];
  int m_ptr, m_init_left, m_owner, m_rdata, m_rid;
  bit m_locked, m_rvalid;
  logic [NREQ-1:0] last_gnt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_ptr = 0; m_init_left = DEPTH; m_locked = 0; m_owner = 0;
    m_rvalid = 0; m_rdata = 0; m_rid = 0;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; lock_drv = '0;
  endtask

  task automatic set_req(input int i, input bit w, input int a, input int d);
    bus.req[i] = 1'b1;
    bus.we[i]  = w;
    bus.addr[i*AW +: AW]       = AW'(a);
    bus.wdata[i*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic cycle();
    int g;
    int a;
    logic [NREQ-1:0] eg;
    g = -1;
    if (m_init_left == 0) begin
      if (m_locked) begin
        if (bus.req[m_owner] && lock_drv[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    @(negedge clk);
    last_gnt = bus.gnt;
    checks++;
    if (bus.gnt !== eg) begin
      errors++;
      $display("FAIL gnt: got %b expected %b at %0t", bus.gnt, eg, $time);
    end
    checks++;
    if (bus.init_busy !== (m_init_left > 0)) begin
      errors++;
      $display("FAIL init_busy: got %b expected %b at %0t", bus.init_busy, (m_init_left > 0), $time);
    end
    @(posedge clk);
    if (m_init_left > 0) begin
      m_init_left--;
      m_rvalid = 0;
    end else if (m_locked && !lock_drv[m_owner]) begin
      m_locked = 0;
      m_ptr = (m_owner + 1) % NREQ;
      m_rvalid = 0;
    end else if (g >= 0) begin
      a = int'(bus.addr[g*AW +: AW]);
      if (bus.we[g]) begin
        m_mem[a] = int'(bus.wdata[g*WIDTH +: WIDTH]);
        m_rvalid = 0;
      end else begin
        m_rdata = m_mem[a];
        m_rid = g;
        m_rvalid = 1;
      end
      if (!m_locked) begin
        m_ptr = (g + 1) % NREQ;
        if (lock_drv[g]) begin m_locked = 1; m_owner = g; end
      end
    end else begin
      m_rvalid = 0;
    end
    #1;
    checks++;
    if (bus.rvalid !== m_rvalid) begin
      errors++;
      $display("FAIL rvalid: got %b expected %b at %0t", bus.rvalid, m_rvalid, $time);
    end
    if (m_rvalid) begin
      checks++;
      if (bus.rdata !== WIDTH'(m_rdata) || bus.rid !== 2'(m_rid)) begin
        errors++;
        $display("FAIL rdata/rid: got %h/%0d expected %h/%0d at %0t",
                 bus.rdata, bus.rid, WIDTH'(m_rdata), m_rid, $time);
      end
    end
  endtask

  // Asserts reset at posedge+1, checks immediate effects, releases a cycle later.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.gnt !== '0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: gnt=%b rvalid=%b expected 0/0", bus.gnt, bus.rvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rdata !== '0 || bus.rid !== '0 || bus.init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_regs: rdata=%h rid=%0d init_busy=%b expected 00/0/1",
               bus.rdata, bus.rid, bus.init_busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req = '1;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle();
  endtask

  task automatic test_init_clear();
    for (int a = 0; a < DEPTH; a++) begin
      clear_inputs();
      set_req(0, 1'b0, a, 0);
      cycle();
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h00) begin
        errors++;
        $display("FAIL init_clear addr %0d: rvalid=%b rdata=%h expected 1/00", a, bus.rvalid, bus.rdata);
      end
    end
  endtask

  task automatic test_rr_all();
    logic [NREQ-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    clear_inputs();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, $urandom_range(DEPTH-1), 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (last_gnt !== seq[i] || bus.rid !== 2'(i % NREQ)) begin
        errors++;
        $display("FAIL rr_sequence step %0d: gnt=%b rid=%0d expected %b/%0d",
                 i, last_gnt, bus.rid, seq[i], i % NREQ);
      end
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    set_req(1, 1'b1, 2, 'hA5);
    cycle();
    clear_inputs();
    set_req(3, 1'b0, 2, 0);
    cycle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 8'hA5 || bus.rid !== 2'd3) begin
      errors++;
      $display("FAIL write_read: rvalid=%b rdata=%h rid=%0d expected 1/a5/3", bus.rvalid, bus.rdata, bus.rid);
    end
  endtask

  task automatic test_back_to_back();
    int run;
    run = 0;
    clear_inputs();
    set_req(2, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.addr[2*AW +: AW] = AW'(i % DEPTH);
      cycle();
      if (bus.rvalid === 1'b1 && last_gnt === 4'b0100) run++;
    end
    checks++;
    if (run != 5) begin
      errors++;
      $display("FAIL back_to_back: %0d granted reads with rvalid, expected 5", run);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.req   = NREQ'($urandom);
      bus.we    = NREQ'($urandom);
      bus.addr  = ADDRW'($urandom);
      bus.wdata = DATW'($urandom);
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    set_req(0, 1'b1, 1, 'h3C);
    cycle();
    clear_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1, 0);
    cycle();
    cycle();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle();
    clear_inputs();
    set_req(0, 1'b0, 1, 0);
    cycle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_clear: rvalid=%b rdata=%h expected 1/00", bus.rvalid, bus.rdata);
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    int first_after;
    clear_inputs();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, i, 0);
    lock_drv = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (last_gnt !== 4'b0001) begin
        errors++;
        $display("FAIL lock_hold step %0d: gnt=%b expected 0001", i, last_gnt);
      end
    end
    lock_drv = '0;
    first_after = -1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (first_after < 0 && last_gnt !== '0) first_after = int'(last_gnt);
    end
    checks++;
    if (first_after != 2) begin
      errors++;
      $display("FAIL lock_release: first gnt after release=%0d expected 2", first_after);
    end
    for (int i = 0; i < 200; i++) begin
      bus.req   = NREQ'($urandom);
      bus.we    = NREQ'($urandom);
      bus.addr  = ADDRW'($urandom);
      bus.wdata = DATW'($urandom);
      lock_drv  = NREQ'($urandom) & NREQ'($urandom);
      cycle();
    end
  endtask
`endif

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_init_clear();
    test_rr_all();
    test_write_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
